// File: rtl/branch_if.sv
// Decode-stage branch bundle: operands and condition select in, decision and bookkeeping out.
// The master side drives operands and funct3; the slave side, branch_unit, returns the results.
interface branch_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
);
  logic [XLEN-1:0]  rs1;
  logic [XLEN-1:0]  rs2;
  logic [2:0]       funct3;
  logic             branchD;
  logic             take_branch;
  logic             take_branch_q;
  logic             illegal_funct3;
  logic [CNT_W-1:0] branch_count;
  logic [CNT_W-1:0] taken_count;

  modport master (
    output rs1, rs2, funct3, branchD,
    input  take_branch, take_branch_q, illegal_funct3, branch_count, taken_count
  );

  modport slave (
    input  rs1, rs2, funct3, branchD,
    output take_branch, take_branch_q, illegal_funct3, branch_count, taken_count
  );
endinterface

// File: rtl/branch_unit.sv
// RV32I decode-stage branch resolution: combinational taken decision plus a registered copy
// of that decision and branch/taken event counters.
module branch_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic     clk,
  input  logic     rst,
  branch_if.slave  bif
);

  typedef enum logic [2:0] {
    F3_BEQ  = 3'b000,
    F3_BNE  = 3'b001,
    F3_RSV2 = 3'b010,
    F3_RSV3 = 3'b011,
    F3_BLT  = 3'b100,
    F3_BGE  = 3'b101,
    F3_BLTU = 3'b110,
    F3_BGEU = 3'b111
  } funct3_e;

  logic             eq, lt, ltu;
  logic             cond;
  logic             take;
  logic             illegal;
  logic             take_q, take_d;
  logic [CNT_W-1:0] bcnt_q, bcnt_d;
  logic [CNT_W-1:0] tcnt_q, tcnt_d;

  // One compare per relation; the complementary encodings reuse them inverted.
  assign eq  = (bif.rs1 == bif.rs2);
  assign lt  = ($signed(bif.rs1) < $signed(bif.rs2));
  assign ltu = (bif.rs1 < bif.rs2);

  always_comb begin
    cond = 1'b0;
    unique case (funct3_e'(bif.funct3))
      F3_BEQ:  cond = eq;
      F3_BNE:  cond = ~eq;
      F3_BLT:  cond = lt;
      F3_BGE:  cond = ~lt;
      F3_BLTU: cond = ltu;
      F3_BGEU: cond = ~ltu;
      F3_RSV2,
      F3_RSV3: cond = 1'b0;
      default: cond = 1'b0;
    endcase
  end

  assign take    = bif.branchD & cond;
  assign illegal = bif.branchD & (bif.funct3[2:1] == 2'b01);

  always_comb begin
    take_d = take;
    bcnt_d = bcnt_q;
    tcnt_d = tcnt_q;
    if (bif.branchD) bcnt_d = bcnt_q + CNT_W'(1);
    if (take)        tcnt_d = tcnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      take_q <= 1'b0;
      bcnt_q <= '0;
      tcnt_q <= '0;
    end else begin
      take_q <= take_d;
      bcnt_q <= bcnt_d;
      tcnt_q <= tcnt_d;
    end
  end

  assign bif.take_branch    = take;
  assign bif.illegal_funct3 = illegal;
  assign bif.take_branch_q  = take_q;
  assign bif.branch_count   = bcnt_q;
  assign bif.taken_count    = tcnt_q;

endmodule

// File: tb/tb_branch_unit.sv
// Scoreboard bench for branch_unit: table-driven expectations for the decode, a counter model,
// plus a CNT_W=4 instance for wrap-around.
module tb_branch_unit;

  logic clk;
  logic rst;

  branch_if #(.XLEN(32), .CNT_W(32)) bif ();
  branch_if #(.XLEN(32), .CNT_W(4))  wif ();

  branch_unit #(.XLEN(32), .CNT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bif (bif)
  );

  branch_unit #(.XLEN(32), .CNT_W(4)) dut_w (
    .clk (clk),
    .rst (rst),
    .bif (wif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic tb;
    logic ill;
  } exp_t;

  exp_t        sbq[$];
  int          n_tot = 0;
  int          n_bad = 0;
  logic [31:0] m_bc;
  logic [31:0] m_tc;
  logic        m_prev;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drive one decode cycle, push its expectation, then check registered state and pop.
  task automatic step(input string tag, input logic [31:0] a, input logic [31:0] b,
                      input logic [2:0] f, input logic br, input logic e_tb, input logic e_ill);
    exp_t e;
    @(posedge clk);
    #1;
    bif.rs1 = a; bif.rs2 = b; bif.funct3 = f; bif.branchD = br;
    sbq.push_back('{tb: e_tb, ill: e_ill});
    @(negedge clk);
    chk({tag, "_tbq"},  {63'd0, bif.take_branch_q}, {63'd0, m_prev});
    chk({tag, "_bcnt"}, {32'd0, bif.branch_count},  {32'd0, m_bc});
    chk({tag, "_tcnt"}, {32'd0, bif.taken_count},   {32'd0, m_tc});
    if (sbq.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'd0, 64'd1);
    end else begin
      e = sbq.pop_front();
      chk({tag, "_take"}, {63'd0, bif.take_branch},    {63'd0, e.tb});
      chk({tag, "_ill"},  {63'd0, bif.illegal_funct3}, {63'd0, e.ill});
      m_bc   = m_bc + {31'd0, br};
      m_tc   = m_tc + {31'd0, e.tb};
      m_prev = e.tb;
    end
  endtask

  // Sweep all eight funct3 values with one operand pair; bit f of tk is the required decision.
  task automatic sweep(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic br, input logic [7:0] tk);
    for (int f = 0; f < 8; f++) begin
      logic [7:0] ill_tab;
      ill_tab = 8'h0C;
      step($sformatf("%s_f%0d", tag, f), a, b, 3'(f), br,
           br & tk[f], br & ill_tab[f]);
    end
  endtask

  initial begin
    logic [2:0] seq [8];
    seq = '{3'd0, 3'd1, 3'd5, 3'd7, 3'd4, 3'd7, 3'd6, 3'd0};
    m_bc = '0; m_tc = '0; m_prev = 1'b0;

    // Reset held for 5 cycles while branches that would be taken are presented.
    rst = 1'b1;
    bif.rs1 = 32'h0; bif.rs2 = 32'h0; bif.funct3 = 3'd0; bif.branchD = 1'b1;
    wif.rs1 = 32'h0; wif.rs2 = 32'h0; wif.funct3 = 3'd0; wif.branchD = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rst_tbq",  {63'd0, bif.take_branch_q}, 64'd0);
      chk("rst_bcnt", {32'd0, bif.branch_count},  64'd0);
      chk("rst_tcnt", {32'd0, bif.taken_count},   64'd0);
      chk("rst_comb_take", {63'd0, bif.take_branch}, 64'd1);
    end
    bif.branchD = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Eight branches, five taken, on equal operands.
    for (int i = 0; i < 8; i++) begin
      logic [7:0] eqtab;
      eqtab = 8'hA1;
      step($sformatf("cnt%0d", i), 32'h1234_5678, 32'h1234_5678, seq[i], 1'b1,
           eqtab[seq[i]], 1'b0);
    end
    step("cnt_idle", 32'h0, 32'h1, 3'd1, 1'b0, 1'b0, 1'b0);
    chk("cnt_b8", {32'd0, bif.branch_count}, 64'd8);
    chk("cnt_t5", {32'd0, bif.taken_count},  64'd5);

    // Reset between edges clears the counters before the next edge.
    step("pre_mid", 32'h5, 32'h5, 3'd0, 1'b1, 1'b1, 1'b0);
    step("pre_mid2", 32'h5, 32'h5, 3'd0, 1'b1, 1'b1, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_bcnt", {32'd0, bif.branch_count},  64'd0);
    chk("mid_tcnt", {32'd0, bif.taken_count},   64'd0);
    chk("mid_tbq",  {63'd0, bif.take_branch_q}, 64'd0);
    bif.branchD = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    m_bc = '0; m_tc = '0; m_prev = 1'b0;

    sweep("sweep", 32'h6785_319A, 32'h0888_0219, 1'b1, 8'hA2);
    sweep("sgn",   32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 8'h92);
    sweep("equ",   32'h8000_0000, 32'h8000_0000, 1'b1, 8'hA1);
    sweep("gate_a", 32'h6785_319A, 32'h0888_0219, 1'b0, 8'hA2);
    sweep("gate_b", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 8'h92);
    sweep("gate_c", 32'h8000_0000, 32'h8000_0000, 1'b0, 8'hA1);
    step("gate_end", 32'h0, 32'h0, 3'd0, 1'b0, 1'b0, 1'b0);
    chk("gate_b24", {32'd0, bif.branch_count}, 64'd24);

    // Narrow-counter instance: 17 taken branches wrap both counters to 1.
    for (int i = 1; i <= 17; i++) begin
      @(posedge clk);
      #1;
      wif.rs1 = 32'hCAFE_0000; wif.rs2 = 32'hCAFE_0000; wif.funct3 = 3'd0; wif.branchD = 1'b1;
      @(negedge clk);
      if (i == 16) chk("wrap_t15", {60'd0, wif.taken_count}, 64'd15);
      if (i == 17) chk("wrap_t0",  {60'd0, wif.taken_count}, 64'd0);
    end
    @(posedge clk);
    #1;
    wif.branchD = 1'b0;
    @(negedge clk);
    chk("wrap_tcnt", {60'd0, wif.taken_count},  64'd1);
    chk("wrap_bcnt", {60'd0, wif.branch_count}, 64'd1);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
